// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, redirect flush and operand forwarding control
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REG_AW-1:0]      id_rs_i,
  input  logic [REG_AW-1:0]      id_rt_i,
  input  logic                   id_rs_used_i,
  input  logic                   id_rt_used_i,
  input  logic [REG_AW-1:0]      ex_rs_i,
  input  logic [REG_AW-1:0]      ex_rt_i,
  input  logic [REG_AW-1:0]      ex_dst_i,
  input  logic                   ex_memread_i,
  input  logic                   ex_regwrite_i,
  input  logic [REG_AW-1:0]      mem_dst_i,
  input  logic                   mem_regwrite_i,
  input  logic [REG_AW-1:0]      wb_dst_i,
  input  logic                   wb_regwrite_i,
  input  logic                   branch_taken_i,
  input  logic                   cnt_clr_i,
  output logic                   stall_o,
  output logic                   bubble_o,
  output logic [FLUSH_DEPTH-1:0] flush_o,
  output logic [1:0]             fwd_a_o,
  output logic [1:0]             fwd_b_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o,
  output logic                   busy_o
);

  localparam int REM_W = $clog2(LOAD_LAT) + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               ld_hit;
  logic               stall;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               unused_regwrite;

  // ex_regwrite_i is implied by ex_memread_i for loads; kept on the port for completeness
  assign unused_regwrite = ex_regwrite_i;

  // Load in EX whose destination is read by the instruction in ID; register 0 never hazards
  always_comb begin
    ld_hit = 1'b0;
    if (ex_memread_i && (ex_dst_i != '0)) begin
      ld_hit = (id_rs_used_i && (id_rs_i == ex_dst_i)) ||
               (id_rt_used_i && (id_rt_i == ex_dst_i));
    end
  end

  // Stall FSM next state; a redirect cancels any stall, including one already in HOLD
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    if (branch_taken_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_hit) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = HOLD;
              rem_d   = REM_W'(LOAD_LAT - 1);
            end
          end
        end
        HOLD: begin
          stall = 1'b1;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Outputs are gated by reset so they drop immediately when reset asserts
  always_comb begin
    stall_o  = rst_i & stall;
    bubble_o = rst_i & (stall | branch_taken_i);
    flush_o  = (rst_i && branch_taken_i) ? {FLUSH_DEPTH{1'b1}} : '0;
    busy_o   = rst_i & (state_q == HOLD);
  end

  // Forwarding select: MEM result has priority over WB result
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (mem_regwrite_i && (mem_dst_i != '0) && (mem_dst_i == ex_rs_i)) begin
      fwd_a_o = 2'b10;
    end else if (wb_regwrite_i && (wb_dst_i != '0) && (wb_dst_i == ex_rs_i)) begin
      fwd_a_o = 2'b01;
    end
    if (mem_regwrite_i && (mem_dst_i != '0) && (mem_dst_i == ex_rt_i)) begin
      fwd_b_o = 2'b10;
    end else if (wb_regwrite_i && (wb_dst_i != '0) && (wb_dst_i == ex_rt_i)) begin
      fwd_b_o = 2'b01;
    end
  end

  // Saturating event counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_o && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (branch_taken_i && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State, down-counter and event counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       rs_used, rt_used, ex_mr, ex_rw, mem_rw, wb_rw, br, clr;

  logic       stall1, bubble1, busy1, stall3, bubble3, busy3;
  logic [2:0] flush1, flush3;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [3:0] sc1_o, fc1_o;
  logic [15:0] sc3_o, fc3_o;

  int n_vec = 0;
  int n_err = 0;

  // model state: stall cycles still owed after the current one, and event totals
  int hl1, sc1, fc1, hl3, sc3, fc3;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(3), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
    .ex_dst_i(ex_dst), .ex_memread_i(ex_mr), .ex_regwrite_i(ex_rw),
    .mem_dst_i(mem_dst), .mem_regwrite_i(mem_rw), .wb_dst_i(wb_dst), .wb_regwrite_i(wb_rw),
    .branch_taken_i(br), .cnt_clr_i(clr), .stall_o(stall1), .bubble_o(bubble1),
    .flush_o(flush1), .fwd_a_o(fa1), .fwd_b_o(fb1), .stall_cnt_o(sc1_o),
    .flush_cnt_o(fc1_o), .busy_o(busy1));

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(3), .CNT_W(16)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
    .ex_dst_i(ex_dst), .ex_memread_i(ex_mr), .ex_regwrite_i(ex_rw),
    .mem_dst_i(mem_dst), .mem_regwrite_i(mem_rw), .wb_dst_i(wb_dst), .wb_regwrite_i(wb_rw),
    .branch_taken_i(br), .cnt_clr_i(clr), .stall_o(stall3), .bubble_o(bubble3),
    .flush_o(flush3), .fwd_a_o(fa3), .fwd_b_o(fb3), .stall_cnt_o(sc3_o),
    .flush_cnt_o(fc3_o), .busy_o(busy3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit ld_hit();
    return ex_mr && (ex_dst != 0) &&
           ((rs_used && id_rs == ex_dst) || (rt_used && id_rt == ex_dst));
  endfunction

  function automatic bit exp_stall(input int hl);
    return rst_n && !br && (hl > 0 || ld_hit());
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (mem_rw && mem_dst != 0 && mem_dst == src) return 2'b10;
    if (wb_rw && wb_dst != 0 && wb_dst == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic upd(inout int hl, inout int sc, inout int fc, input int lat, input int mx);
    bit st;
    st = exp_stall(hl);
    if (clr) begin
      sc = 0;
      fc = 0;
    end else begin
      if (st && sc < mx) sc++;
      if (br && fc < mx) fc++;
    end
    if (br) hl = 0;
    else if (hl > 0) hl--;
    else if (ld_hit()) hl = lat - 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hl1 = 0; sc1 = 0; fc1 = 0;
      hl3 = 0; sc3 = 0; fc3 = 0;
    end else begin
      upd(hl1, sc1, fc1, 1, 15);
      upd(hl3, sc3, fc3, 3, 65535);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("d1.stall",  32'(stall1),  32'(exp_stall(hl1)));
    chk("d1.bubble", 32'(bubble1), 32'(rst_n && (exp_stall(hl1) || br)));
    chk("d1.flush",  32'(flush1),  (rst_n && br) ? 32'h7 : 32'h0);
    chk("d1.busy",   32'(busy1),   32'(rst_n && hl1 > 0));
    chk("d1.fwd_a",  32'(fa1),     32'(exp_fwd(ex_rs)));
    chk("d1.fwd_b",  32'(fb1),     32'(exp_fwd(ex_rt)));
    chk("d1.scnt",   32'(sc1_o),   32'(sc1));
    chk("d1.fcnt",   32'(fc1_o),   32'(fc1));
    chk("d3.stall",  32'(stall3),  32'(exp_stall(hl3)));
    chk("d3.bubble", 32'(bubble3), 32'(rst_n && (exp_stall(hl3) || br)));
    chk("d3.flush",  32'(flush3),  (rst_n && br) ? 32'h7 : 32'h0);
    chk("d3.busy",   32'(busy3),   32'(rst_n && hl3 > 0));
    chk("d3.fwd_a",  32'(fa3),     32'(exp_fwd(ex_rs)));
    chk("d3.fwd_b",  32'(fb3),     32'(exp_fwd(ex_rt)));
    chk("d3.scnt",   32'(sc3_o),   32'(sc3));
    chk("d3.fcnt",   32'(fc3_o),   32'(fc3));
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
    rs_used = 0; rt_used = 0; ex_mr = 0; ex_rw = 0; mem_rw = 0; wb_rw = 0; br = 0; clr = 0;
  endtask

  task automatic hit_in();
    idle_in();
    ex_mr = 1; ex_rw = 1; ex_dst = 5; id_rs = 5; rs_used = 1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic mr; logic [4:0] exd; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
    logic mw; logic [4:0] md; logic ww; logic [4:0] wd; logic [4:0] exrs; logic [4:0] exrt;
    logic stall; logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  vec_t tbl[9];
  int   s_sum, b_sum;

  initial begin
    tbl[0] = '{1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00};
    tbl[1] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[2] = '{1, 5, 3, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[3] = '{1, 5, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00};
    tbl[4] = '{0, 5, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 7, 7, 0, 2'b10, 2'b10};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 7, 1, 7, 7, 2, 0, 2'b01, 2'b00};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 4, 4, 3, 0, 2'b01, 2'b10};

    // reset state: outputs forced low even with hit and redirect applied
    rst_n = 0;
    hit_in();
    br = 1;
    #12;
    to_neg();
    chk("rst.stall", 32'(stall3), 0);
    chk("rst.flush", 32'(flush3), 0);
    chk("rst.bubble", 32'(bubble1), 0);
    to_next();
    idle_in();
    rst_n = 1;
    to_next();

    // table vectors, checked against dut1 which never leaves IDLE
    foreach (tbl[i]) begin
      idle_in();
      ex_mr = tbl[i].mr; ex_dst = tbl[i].exd; id_rs = tbl[i].rs; rs_used = tbl[i].rsu;
      id_rt = tbl[i].rt; rt_used = tbl[i].rtu; mem_rw = tbl[i].mw; mem_dst = tbl[i].md;
      wb_rw = tbl[i].ww; wb_dst = tbl[i].wd; ex_rs = tbl[i].exrs; ex_rt = tbl[i].exrt;
      to_neg();
      chk($sformatf("tbl%0d.stall", i), 32'(stall1), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d.fwd_a", i), 32'(fa1), 32'(tbl[i].fa));
      chk($sformatf("tbl%0d.fwd_b", i), 32'(fb1), 32'(tbl[i].fb));
      to_next();
    end
    idle_in();
    repeat (4) begin to_neg(); to_next(); end

    // single load-use hit: 1-cycle stall on LAT=1, 3-cycle stall with 2 busy on LAT=3
    clr = 1;
    to_neg(); to_next();
    hit_in();
    to_neg();
    chk("lu.d1.stall", 32'(stall1), 1);
    chk("lu.d1.busy", 32'(busy1), 0);
    s_sum = int'(stall3);
    b_sum = int'(busy3);
    to_next();
    idle_in();
    for (int c = 0; c < 5; c++) begin
      to_neg();
      s_sum += int'(stall3);
      b_sum += int'(busy3);
      to_next();
    end
    chk("lu.d3.stall_cycles", 32'(s_sum), 3);
    chk("lu.d3.busy_cycles", 32'(b_sum), 2);
    chk("lu.d1.scnt", 32'(sc1_o), 1);
    chk("lu.d3.scnt", 32'(sc3_o), 3);

    // redirect in the second HOLD cycle of a LAT=3 stall
    clr = 1;
    to_neg(); to_next();
    hit_in();
    to_neg(); to_next();
    idle_in();
    to_neg(); to_next();
    br = 1;
    to_neg();
    chk("br.flush", 32'(flush3), 32'h7);
    chk("br.stall", 32'(stall3), 0);
    chk("br.bubble", 32'(bubble3), 1);
    to_next();
    idle_in();
    to_neg();
    chk("br.busy_after", 32'(busy3), 0);
    chk("br.fcnt", 32'(fc3_o), 1);
    to_next();

    // asynchronous reset in the middle of HOLD
    hit_in();
    to_neg(); to_next();
    idle_in();
    to_neg();
    chk("ar.busy_before", 32'(busy3), 1);
    #2;
    rst_n = 0;
    #1;
    check_all();
    chk("ar.stall", 32'(stall3), 0);
    chk("ar.busy", 32'(busy3), 0);
    chk("ar.scnt", 32'(sc3_o), 0);
    to_next();
    rst_n = 1;
    to_neg();
    chk("ar.idle_after", 32'(busy3), 0);
    to_next();

    // clear while stalling: clear wins
    hit_in();
    to_neg(); to_next();
    hit_in();
    clr = 1;
    to_neg();
    chk("clr.stall1", 32'(stall1), 1);
    to_next();
    idle_in();
    to_neg();
    chk("clr.scnt1", 32'(sc1_o), 0);
    to_next();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3));
      wb_dst = 5'($urandom_range(0, 3));
      rs_used = 1'($urandom); rt_used = 1'($urandom); ex_mr = 1'($urandom);
      ex_rw = 1'($urandom); mem_rw = 1'($urandom); wb_rw = 1'($urandom);
      br = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 24) == 0);
      to_neg(); to_next();
    end

    // counter saturation on the 4-bit instance
    idle_in();
    clr = 1;
    to_neg(); to_next();
    hit_in();
    for (int c = 0; c < 20; c++) begin to_neg(); to_next(); end
    idle_in();
    br = 1;
    for (int c = 0; c < 20; c++) begin to_neg(); to_next(); end
    idle_in();
    to_neg();
    chk("sat.scnt1", 32'(sc1_o), 15);
    chk("sat.fcnt1", 32'(fc1_o), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
